// File: rtl/bound_flasher_gen.sv
// bound_flasher_gen: parametrised thermometer LED flasher
// flick starts/kicks back, hold freezes, done pulses at end
module bound_flasher_gen #(
  parameter int N        = 16,
  parameter int LO       = 5,
  parameter int HI       = 10,
  parameter int STEP_DIV = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flick,
  input  logic         hold,
  output logic [N-1:0] LED,
  output logic         busy,
  output logic         done,
  output logic [2:0]   phase
);

  localparam int LW = $clog2(N + 1);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [LW-1:0] LN  = LW'(N);
  localparam logic [LW-1:0] LLO = LW'(LO);
  localparam logic [LW-1:0] LHI = LW'(HI);
  localparam logic [DW-1:0] DMAX = DW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } state_t;

  state_t        state;
  state_t        adv;
  logic [LW-1:0] lvl;
  logic [LW-1:0] nxt;
  logic [LW-1:0] tgt;
  logic [DW-1:0] div;
  logic          pend;
  logic          tick;
  logic          dnph;
  logic          up;
  logic          kick;
  logic          hit;

  // step decode: next level, phase target and kickback
  always_comb begin
    tick = (state != IDLE) && !hold && (div == DMAX);
    dnph = (state == DN1) || (state == DN2);
    up   = (state == UP1) || (state == UP2) ||
           (state == UP3);
    nxt  = up ? lvl + 1'b1 : lvl - 1'b1;
    tgt  = '0;
    adv  = IDLE;
    unique case (state)
      UP1:     begin tgt = LN;  adv = DN1; end
      DN1:     begin tgt = LLO; adv = UP2; end
      UP2:     begin tgt = LHI; adv = DN2; end
      DN2:     begin tgt = '0;  adv = UP3; end
      UP3:     begin tgt = LLO; adv = DN3; end
      DN3:     begin tgt = '0;  adv = IDLE; end
      default: begin tgt = '0;  adv = IDLE; end
    endcase
    hit  = (nxt == tgt);
    kick = dnph && ((nxt == LLO) || (nxt == LHI)) &&
           (flick || pend);
  end

  // sequencer: state, level, divider, pend, done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lvl   <= '0;
      div   <= '0;
      pend  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        pend <= 1'b0;
        if (!hold && flick) begin
          state <= UP1;
          lvl   <= LW'(1);
          div   <= '0;
        end
      end else begin
        if (!hold)
          div <= tick ? '0 : div + 1'b1;
        if (tick) begin
          pend <= 1'b0;
          lvl  <= nxt;
          if (kick)
            state <= (state == DN1) ? UP1 : UP2;
          else if (hit)
            state <= adv;
          done <= !kick && hit && (state == DN3);
        end else if (dnph && flick) begin
          pend <= 1'b1;
        end
      end
    end
  end

  // thermometer decode of the level register
  always_comb begin
    for (int i = 0; i < N; i++)
      LED[i] = (LW'(i) < lvl);
  end

  assign busy  = (state != IDLE);
  assign phase = state;

endmodule
